// File: rtl/fat32_pkg.sv
// FAT32 volume parser shared types: FSM states, error codes, on-disk field offsets.
// No logic of its own; the only function is a combinational priority encoder.
// Imported by the parser top and its translation stage.
package fat32_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_REQ_MBR, S_CAP_MBR, S_CHK_MBR, S_REQ_BPB,
      S_CAP_BPB, S_CHK_BPB, S_CALC, S_DONE, S_ERROR
   } state_t;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_SIG   = 3'd1;
   localparam logic [2:0] ERR_PART  = 3'd2;
   localparam logic [2:0] ERR_BPS   = 3'd3;
   localparam logic [2:0] ERR_SPC   = 3'd4;
   localparam logic [2:0] ERR_NFATS = 3'd5;
   localparam logic [2:0] ERR_FATSZ = 3'd6;

   // Byte offsets inside sector 0 (MBR) and the volume boot sector (BPB)
   localparam int OFF_BPS   = 'h0B;
   localparam int OFF_SPC   = 'h0D;
   localparam int OFF_RSVD  = 'h0E;
   localparam int OFF_NFATS = 'h10;
   localparam int OFF_FATSZ = 'h24;
   localparam int OFF_ROOT  = 'h2C;
   localparam int OFF_PTAB  = 'h1BE;
   localparam int OFF_SIG   = 'h1FE;

   localparam logic [7:0] PTYPE_FAT32_CHS = 8'h0B;
   localparam logic [7:0] PTYPE_FAT32_LBA = 8'h0C;
   localparam logic [7:0] JMP_SHORT       = 8'hEB;
   localparam logic [7:0] JMP_NEAR        = 8'hE9;

   // Index of the highest set bit; spc is already checked to be a power of two
   function automatic logic [2:0] spc_log2(input logic [7:0] spc);
      logic [2:0] v = 3'd0;
      for (int i = 0; i < 8; i++)
         if (spc[i]) v = 3'(i);
      return v;
   endfunction

endpackage

// File: rtl/fat32_volume_parser_if.sv
// Bundle between the parser, the SD sector reader and the file-write controller.
// Pure wiring, no latency.
// No backpressure: the reader streams bytes, the parser only issues sector requests.
interface fat32_volume_parser_if #(parameter int ADDR_W = 9);
   logic              start;
   logic              rd_req;
   logic [31:0]       rd_lba;
   logic              byte_valid;
   logic [ADDR_W-1:0] byte_addr;
   logic [7:0]        byte_data;
   logic              sector_end;
   logic              busy;
   logic              done;
   logic              error;
   logic [2:0]        err_code;
   logic [31:0]       part_lba;
   logic [31:0]       fat_start_lba;
   logic [31:0]       data_start_lba;
   logic [7:0]        sectors_per_cluster;
   logic [31:0]       root_cluster;
   logic              clus_valid;
   logic [31:0]       clus_num;
   logic              lba_valid;
   logic [31:0]       lba_out;
   logic              clus_err;

   // Parser side
   modport master (
      input  start, byte_valid, byte_addr, byte_data, sector_end, clus_valid, clus_num,
      output rd_req, rd_lba, busy, done, error, err_code, part_lba, fat_start_lba,
             data_start_lba, sectors_per_cluster, root_cluster, lba_valid, lba_out, clus_err
   );

   // Reader / controller side
   modport slave (
      output start, byte_valid, byte_addr, byte_data, sector_end, clus_valid, clus_num,
      input  rd_req, rd_lba, busy, done, error, err_code, part_lba, fat_start_lba,
             data_start_lba, sectors_per_cluster, root_cluster, lba_valid, lba_out, clus_err
   );
endinterface

// File: rtl/fat32_cluster_to_lba.sv
// Cluster number to sector LBA translation for the data region.
// Latency 1 cycle: result and clus_err pulse the cycle after an accepted request.
// No backpressure: every accepted request produces exactly one result.
module fat32_cluster_to_lba (
   input  logic        Clock,
   input  logic        sys_rst_n,
   input  logic        i_clus_valid,
   input  logic        i_enable,
   input  logic [31:0] i_clus_num,
   input  logic [31:0] i_data_start,
   input  logic [2:0]  i_shift,
   output logic        o_lba_valid,
   output logic [31:0] o_lba,
   output logic        o_clus_err
);
   logic        r_vld;
   logic        r_err;
   logic [31:0] r_lba;
   logic [31:0] w_off;
   logic        w_bad;

   assign w_off = (i_clus_num - 32'd2) << i_shift;
   assign w_bad = (i_clus_num < 32'd2);

   // Register one translation per accepted request; clusters 0/1 are not data clusters
   always_ff @(posedge Clock or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_vld <= 1'b0;
         r_err <= 1'b0;
         r_lba <= 32'd0;
      end else begin
         r_vld <= i_clus_valid & i_enable;
         r_err <= i_clus_valid & i_enable & w_bad;
         if (i_clus_valid && i_enable)
            r_lba <= w_bad ? 32'd0 : (i_data_start + w_off);
      end
   end

   assign o_lba_valid = r_vld;
   assign o_lba       = r_lba;
   assign o_clus_err  = r_err;
endmodule

// File: rtl/fat32_volume_parser.sv
// Mounts a FAT32 volume: reads MBR (or superfloppy boot sector), then BPB, derives geometry.
// Latency: two sector transfers plus 2+NumFATs cycles; translation results 1 cycle after request.
// No backpressure on the byte stream; one outstanding sector request at a time.
module fat32_volume_parser
   import fat32_pkg::*;
#(
   parameter int SECTOR_BYTES      = 512,
   parameter int ADDR_W            = 9,
   parameter int PART_INDEX        = 0,
   parameter int CHECK_SIGNATURE   = 1,
   parameter int ALLOW_SUPERFLOPPY = 1
) (
   input  logic Clock,
   input  logic sys_rst_n,
   fat32_volume_parser_if.master bus
);
   localparam int PENT = OFF_PTAB + 16 * PART_INDEX;

   state_t      r_state, w_next;
   logic        r_sig55, r_sigaa;
   logic [7:0]  r_byte0, r_spc, r_nfats, r_ptype, r_cnt, r_spc_o;
   logic [15:0] r_bps, r_rsvd;
   logic [31:0] r_fatsz, r_root, r_plba;
   logic [31:0] r_rd_lba, r_part_lba, r_fat_start, r_acc, r_data_start, r_root_o;
   logic [2:0]  r_err_code, r_shift;
   logic        w_cap, w_sig_ok, w_superfloppy, w_part_ok, w_spc_ok;
   logic [2:0]  w_mbr_err, w_bpb_err;
   logic        w_rd_req, w_busy, w_done, w_error;

   assign w_cap         = bus.byte_valid && (r_state == S_CAP_MBR || r_state == S_CAP_BPB);
   assign w_sig_ok      = (CHECK_SIGNATURE == 0) || (r_sig55 && r_sigaa);
   assign w_superfloppy = (ALLOW_SUPERFLOPPY != 0) && (r_byte0 == JMP_SHORT || r_byte0 == JMP_NEAR)
                          && (r_bps == 16'(SECTOR_BYTES));
   assign w_part_ok     = (r_ptype == PTYPE_FAT32_CHS || r_ptype == PTYPE_FAT32_LBA) && (r_plba != 32'd0);
   assign w_spc_ok      = (r_spc != 8'd0) && ((r_spc & (r_spc - 8'd1)) == 8'd0);

   // Ordered validity checks: the first failing check names the error
   always_comb begin
      w_mbr_err = ERR_NONE;
      w_bpb_err = ERR_NONE;
      if (!w_sig_ok)                      w_mbr_err = ERR_SIG;
      else if (!w_superfloppy && !w_part_ok) w_mbr_err = ERR_PART;
      if (!w_sig_ok)                      w_bpb_err = ERR_SIG;
      else if (r_bps != 16'(SECTOR_BYTES)) w_bpb_err = ERR_BPS;
      else if (!w_spc_ok)                 w_bpb_err = ERR_SPC;
      else if (r_nfats == 8'd0)           w_bpb_err = ERR_NFATS;
      else if (r_fatsz == 32'd0)          w_bpb_err = ERR_FATSZ;
   end

   // State register
   always_ff @(posedge Clock or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: if (bus.start) w_next = S_REQ_MBR;
         S_REQ_MBR: w_next = S_CAP_MBR;
         S_CAP_MBR: if (bus.sector_end) w_next = S_CHK_MBR;
         S_CHK_MBR: w_next = (w_mbr_err != ERR_NONE) ? S_ERROR :
                             (w_superfloppy ? S_CHK_BPB : S_REQ_BPB);
         S_REQ_BPB: w_next = S_CAP_BPB;
         S_CAP_BPB: if (bus.sector_end) w_next = S_CHK_BPB;
         S_CHK_BPB: w_next = (w_bpb_err != ERR_NONE) ? S_ERROR : S_CALC;
         S_CALC:    if (r_cnt == 8'd1) w_next = S_DONE;
         default:   w_next = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      w_rd_req = (r_state == S_REQ_MBR) || (r_state == S_REQ_BPB);
      w_done   = (r_state == S_DONE);
      w_error  = (r_state == S_ERROR);
      w_busy   = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
   end

   // Field capture from the byte stream plus geometry computation per state
   always_ff @(posedge Clock or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sig55 <= 1'b0;  r_sigaa <= 1'b0;  r_byte0 <= 8'd0;  r_spc <= 8'd0;
         r_nfats <= 8'd0;  r_ptype <= 8'd0;  r_cnt <= 8'd0;    r_spc_o <= 8'd0;
         r_bps <= 16'd0;   r_rsvd <= 16'd0;  r_fatsz <= 32'd0; r_root <= 32'd0;
         r_plba <= 32'd0;  r_rd_lba <= 32'd0; r_part_lba <= 32'd0;
         r_fat_start <= 32'd0; r_acc <= 32'd0; r_data_start <= 32'd0;
         r_root_o <= 32'd0; r_err_code <= ERR_NONE; r_shift <= 3'd0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (bus.start) begin
               r_err_code <= ERR_NONE; r_part_lba <= 32'd0; r_fat_start <= 32'd0;
               r_data_start <= 32'd0;  r_spc_o <= 8'd0;     r_root_o <= 32'd0;
               r_shift <= 3'd0;        r_rd_lba <= 32'd0;
            end
            S_REQ_MBR, S_REQ_BPB: begin
               r_sig55 <= 1'b0;
               r_sigaa <= 1'b0;
            end
            S_CHK_MBR: begin
               if (w_mbr_err != ERR_NONE) r_err_code <= w_mbr_err;
               else if (!w_superfloppy) begin
                  r_part_lba <= r_plba;
                  r_rd_lba   <= r_plba;
               end
            end
            S_CHK_BPB: begin
               if (w_bpb_err != ERR_NONE) r_err_code <= w_bpb_err;
               else begin
                  r_fat_start <= r_part_lba + {16'd0, r_rsvd};
                  r_acc       <= r_part_lba + {16'd0, r_rsvd};
                  r_cnt       <= r_nfats;
                  r_shift     <= spc_log2(r_spc);
               end
            end
            S_CALC: begin
               r_acc <= r_acc + r_fatsz;
               r_cnt <= r_cnt - 8'd1;
               if (r_cnt == 8'd1) begin
                  r_data_start <= r_acc + r_fatsz;
                  r_spc_o      <= r_spc;
                  r_root_o     <= r_root;
               end
            end
            default: ;
         endcase
         if (w_cap) begin
            case (bus.byte_addr)
               ADDR_W'(0):            r_byte0        <= bus.byte_data;
               ADDR_W'(OFF_BPS):      r_bps[7:0]     <= bus.byte_data;
               ADDR_W'(OFF_BPS+1):    r_bps[15:8]    <= bus.byte_data;
               ADDR_W'(OFF_SPC):      r_spc          <= bus.byte_data;
               ADDR_W'(OFF_RSVD):     r_rsvd[7:0]    <= bus.byte_data;
               ADDR_W'(OFF_RSVD+1):   r_rsvd[15:8]   <= bus.byte_data;
               ADDR_W'(OFF_NFATS):    r_nfats        <= bus.byte_data;
               ADDR_W'(OFF_FATSZ):    r_fatsz[7:0]   <= bus.byte_data;
               ADDR_W'(OFF_FATSZ+1):  r_fatsz[15:8]  <= bus.byte_data;
               ADDR_W'(OFF_FATSZ+2):  r_fatsz[23:16] <= bus.byte_data;
               ADDR_W'(OFF_FATSZ+3):  r_fatsz[31:24] <= bus.byte_data;
               ADDR_W'(OFF_ROOT):     r_root[7:0]    <= bus.byte_data;
               ADDR_W'(OFF_ROOT+1):   r_root[15:8]   <= bus.byte_data;
               ADDR_W'(OFF_ROOT+2):   r_root[23:16]  <= bus.byte_data;
               ADDR_W'(OFF_ROOT+3):   r_root[31:24]  <= bus.byte_data;
               ADDR_W'(PENT+4):       r_ptype        <= bus.byte_data;
               ADDR_W'(PENT+8):       r_plba[7:0]    <= bus.byte_data;
               ADDR_W'(PENT+9):       r_plba[15:8]   <= bus.byte_data;
               ADDR_W'(PENT+10):      r_plba[23:16]  <= bus.byte_data;
               ADDR_W'(PENT+11):      r_plba[31:24]  <= bus.byte_data;
               ADDR_W'(OFF_SIG):      r_sig55        <= (bus.byte_data == 8'h55);
               ADDR_W'(OFF_SIG+1):    r_sigaa        <= (bus.byte_data == 8'hAA);
               default: ;
            endcase
         end
      end
   end

   fat32_cluster_to_lba u_c2l (
      .Clock        (Clock),
      .sys_rst_n    (sys_rst_n),
      .i_clus_valid (bus.clus_valid),
      .i_enable     (w_done),
      .i_clus_num   (bus.clus_num),
      .i_data_start (r_data_start),
      .i_shift      (r_shift),
      .o_lba_valid  (bus.lba_valid),
      .o_lba        (bus.lba_out),
      .o_clus_err   (bus.clus_err)
   );

   assign bus.rd_req              = w_rd_req;
   assign bus.rd_lba              = r_rd_lba;
   assign bus.busy                = w_busy;
   assign bus.done                = w_done;
   assign bus.error               = w_error;
   assign bus.err_code            = r_err_code;
   assign bus.part_lba            = r_part_lba;
   assign bus.fat_start_lba       = r_fat_start;
   assign bus.data_start_lba      = r_data_start;
   assign bus.sectors_per_cluster = r_spc_o;
   assign bus.root_cluster        = r_root_o;
endmodule

// File: tb/tb_fat32_volume_parser.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor pops and compares them.
module tb_fat32_volume_parser;
   localparam int K_RD = 0, K_DONE = 1, K_ERR = 2, K_LBA = 3;

   typedef struct {
      int          kind;
      logic [31:0] a, b, c, d, e;
   } exp_t;

   logic Clock = 1'b0;
   logic sys_rst_n = 1'b0;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic [7:0] sec [0:1][0:511];

   fat32_volume_parser_if #(.ADDR_W(9)) bus ();

   fat32_volume_parser #(
      .SECTOR_BYTES(512), .ADDR_W(9), .PART_INDEX(0),
      .CHECK_SIGNATURE(1), .ALLOW_SUPERFLOPPY(1)
   ) dut (
      .Clock     (Clock),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic pop(input int kind, output exp_t e, output bit ok);
      checks++;
      ok = 1'b0;
      e = '{kind: -1, default: '0};
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event actual_kind=%0d required=none", kind);
      end else begin
         e = q.pop_front();
         if (e.kind != kind) begin
            errors++;
            $display("FAIL event_order actual_kind=%0d required_kind=%0d", kind, e.kind);
         end else ok = 1'b1;
      end
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d, input logic [31:0] e);
      exp_t x;
      x.kind = kind; x.a = a; x.b = b; x.c = c; x.d = d; x.e = e;
      q.push_back(x);
   endtask

   // Monitor: compares every DUT output event against the head of the queue
   bit prev_acc = 1'b0, pdone = 1'b0, perr = 1'b0;
   always @(negedge Clock) begin
      exp_t e;
      bit   ok;
      if (bus.lba_valid || prev_acc) chk("lba_latency", 32'(bus.lba_valid), 32'(prev_acc));
      prev_acc = bus.clus_valid && bus.done;
      if (bus.rd_req) begin
         pop(K_RD, e, ok);
         if (ok) chk("rd_lba", bus.rd_lba, e.a);
      end
      if (bus.done && !pdone) begin
         pop(K_DONE, e, ok);
         if (ok) begin
            chk("part_lba", bus.part_lba, e.a);
            chk("fat_start_lba", bus.fat_start_lba, e.b);
            chk("data_start_lba", bus.data_start_lba, e.c);
            chk("sectors_per_cluster", 32'(bus.sectors_per_cluster), e.d);
            chk("root_cluster", bus.root_cluster, e.e);
         end
      end
      if (bus.error && !perr) begin
         pop(K_ERR, e, ok);
         if (ok) chk("err_code", 32'(bus.err_code), e.a);
      end
      if (bus.lba_valid) begin
         pop(K_LBA, e, ok);
         if (ok) begin
            chk("lba_out", bus.lba_out, e.a);
            chk("clus_err", 32'(bus.clus_err), e.b);
         end
      end
      pdone = bus.done;
      perr  = bus.error;
   end

   task automatic tick();
      @(posedge Clock); #1;
   endtask

   task automatic clear_sec(input int s);
      for (int i = 0; i < 512; i++) sec[s][i] = 8'h00;
      sec[s][510] = 8'h55;
      sec[s][511] = 8'hAA;
   endtask

   task automatic put_mbr(input int s, input logic [7:0] ptype, input logic [31:0] lba);
      sec[s][450] = ptype;
      for (int i = 0; i < 4; i++) sec[s][454+i] = lba[8*i +: 8];
   endtask

   task automatic put_bpb(input int s, input logic [7:0] b0, input logic [15:0] bps,
                          input logic [7:0] spc, input logic [15:0] rsvd, input logic [7:0] nf,
                          input logic [31:0] fsz, input logic [31:0] root);
      sec[s][0]  = b0;
      sec[s][11] = bps[7:0];  sec[s][12] = bps[15:8];
      sec[s][13] = spc;
      sec[s][14] = rsvd[7:0]; sec[s][15] = rsvd[15:8];
      sec[s][16] = nf;
      for (int i = 0; i < 4; i++) begin
         sec[s][36+i] = fsz[8*i +: 8];
         sec[s][44+i] = root[8*i +: 8];
      end
   endtask

   task automatic wait_rd(input string name);
      int n = 0;
      while (!bus.rd_req && n < 2000) begin tick(); n++; end
      if (!bus.rd_req) chk({name, "_rd_req_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_end(input string name);
      int n = 0;
      while (!(bus.done || bus.error) && n < 2000) begin tick(); n++; end
      if (!(bus.done || bus.error)) chk({name, "_end_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic send(input int s, input int nbytes, input bit coinc);
      for (int i = 0; i < nbytes; i++) begin
         tick();
         bus.byte_valid = 1'b1;
         bus.byte_addr  = 9'(i);
         bus.byte_data  = sec[s][i];
         if (coinc && i == 511) bus.sector_end = 1'b1;
      end
      if (nbytes == 512 && !coinc) begin
         tick();
         bus.byte_valid = 1'b0;
         bus.sector_end = 1'b1;
      end
      tick();
      bus.byte_valid = 1'b0;
      bus.sector_end = 1'b0;
   endtask

   task automatic mount(input string name, input bit two, input bit coinc);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk({name, "_clr_done"}, 32'(bus.done), 32'd0);
      chk({name, "_clr_error"}, 32'(bus.error), 32'd0);
      chk({name, "_clr_err_code"}, 32'(bus.err_code), 32'd0);
      chk({name, "_clr_data_start"}, bus.data_start_lba, 32'd0);
      wait_rd(name);
      send(0, 512, 1'b0);
      if (two) begin
         wait_rd(name);
         send(1, 512, coinc);
      end
      wait_end(name);
      repeat (4) tick();
   endtask

   task automatic clus(input logic [31:0] n);
      bus.clus_valid = 1'b1;
      bus.clus_num   = n;
      tick();
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_busy"}, 32'(bus.busy), 32'd0);
      chk({name, "_done"}, 32'(bus.done), 32'd0);
      chk({name, "_error"}, 32'(bus.error), 32'd0);
      chk({name, "_err_code"}, 32'(bus.err_code), 32'd0);
      chk({name, "_rd_req"}, 32'(bus.rd_req), 32'd0);
      chk({name, "_rd_lba"}, bus.rd_lba, 32'd0);
      chk({name, "_part_lba"}, bus.part_lba, 32'd0);
      chk({name, "_fat_start"}, bus.fat_start_lba, 32'd0);
      chk({name, "_data_start"}, bus.data_start_lba, 32'd0);
      chk({name, "_spc"}, 32'(bus.sectors_per_cluster), 32'd0);
      chk({name, "_root"}, bus.root_cluster, 32'd0);
      chk({name, "_lba_out"}, bus.lba_out, 32'd0);
   endtask

   initial begin
      bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_addr = '0; bus.byte_data = 8'd0;
      bus.sector_end = 1'b0; bus.clus_valid = 1'b0; bus.clus_num = 32'd0;
      repeat (3) tick();
      chk_zero("reset");
      sys_rst_n = 1'b1;
      tick();

      // 1: MBR type 0x0C at 8192, BPB spc=8 rsvd=32 nfats=2 fatsz=1000
      clear_sec(0); put_mbr(0, 8'h0C, 32'd8192);
      clear_sec(1); put_bpb(1, 8'hEB, 16'd512, 8'd8, 16'd32, 8'd2, 32'd1000, 32'd2);
      push(K_RD, 0, 0, 0, 0, 0);
      push(K_RD, 8192, 0, 0, 0, 0);
      push(K_DONE, 8192, 8224, 10224, 8, 2);
      mount("t1", 1'b1, 1'b0);

      // 2: back-to-back translations
      push(K_LBA, 10224, 0, 0, 0, 0);
      push(K_LBA, 10248, 0, 0, 0, 0);
      push(K_LBA, 0, 1, 0, 0, 0);
      clus(32'd2); clus(32'd5); clus(32'd1);
      bus.clus_valid = 1'b0;
      repeat (3) tick();

      // 3: bad signature on sector 0, no BPB read
      clear_sec(0); put_mbr(0, 8'h0C, 32'd8192); sec[0][510] = 8'h00;
      push(K_RD, 0, 0, 0, 0, 0);
      push(K_ERR, 1, 0, 0, 0, 0);
      mount("t3", 1'b1 & 1'b0, 1'b0);
      repeat (20) tick();
      clus(32'd7);              // ignored while not done
      bus.clus_valid = 1'b0;
      repeat (3) tick();

      // 4: superfloppy: single read, part_lba 0
      clear_sec(0); put_bpb(0, 8'hEB, 16'd512, 8'd4, 16'd32, 8'd2, 32'd100, 32'd2);
      push(K_RD, 0, 0, 0, 0, 0);
      push(K_DONE, 0, 32, 232, 4, 2);
      mount("t4", 1'b0, 1'b0);
      push(K_LBA, 236, 0, 0, 0, 0);
      clus(32'd3);
      bus.clus_valid = 1'b0;
      repeat (3) tick();

      // 5: bad spc, then zero FAT count
      clear_sec(0); put_mbr(0, 8'h0C, 32'd8192);
      clear_sec(1); put_bpb(1, 8'hEB, 16'd512, 8'd6, 16'd32, 8'd2, 32'd1000, 32'd2);
      push(K_RD, 0, 0, 0, 0, 0); push(K_RD, 8192, 0, 0, 0, 0); push(K_ERR, 4, 0, 0, 0, 0);
      mount("t5a", 1'b1, 1'b0);
      put_bpb(1, 8'hEB, 16'd512, 8'd16, 16'd32, 8'd0, 32'd1000, 32'd2);
      push(K_RD, 0, 0, 0, 0, 0); push(K_RD, 8192, 0, 0, 0, 0); push(K_ERR, 5, 0, 0, 0, 0);
      mount("t5b", 1'b1, 1'b0);

      // 6: reset in the middle of the BPB transfer, then a clean remount
      clear_sec(0); put_mbr(0, 8'h0C, 32'd8192);
      clear_sec(1); put_bpb(1, 8'hEB, 16'd512, 8'd8, 16'd32, 8'd2, 32'd1000, 32'd2);
      push(K_RD, 0, 0, 0, 0, 0); push(K_RD, 8192, 0, 0, 0, 0);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      wait_rd("t6a"); send(0, 512, 1'b0);
      wait_rd("t6a"); send(1, 200, 1'b0);
      sys_rst_n = 1'b0;
      #1;
      chk_zero("t6_rst");
      repeat (5) tick();
      sys_rst_n = 1'b1;
      tick();
      push(K_RD, 0, 0, 0, 0, 0); push(K_RD, 8192, 0, 0, 0, 0);
      push(K_DONE, 8192, 8224, 10224, 8, 2);
      mount("t6b", 1'b1, 1'b1);
      push(K_LBA, 10232, 0, 0, 0, 0);
      clus(32'd3);
      bus.clus_valid = 1'b0;
      repeat (3) tick();

      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
